// File: rtl/rca_wb_pkg.sv
// rca_wb_pkg: shared writeback entry type and default sizing for the RCA writeback arbiter
package rca_wb_pkg;
   localparam int RCA_WB_DEPTH = 4;
   localparam int NUM_RCA_COMMIT = 2;
   localparam int RCA_WB_ID_W = 3;
   typedef logic [RCA_WB_ID_W-1:0] id_t;
   typedef struct packed {
      logic [4:0]  rd;
      id_t         id;
      logic [31:0] data;
   } rca_wb_entry_t;
endpackage

// File: rtl/rca_wb_fifo.sv
// rca_wb_fifo: single-channel result FIFO with occupancy count and synchronous flush
module rca_wb_fifo #(
   parameter int W = 40,
   parameter int DEPTH = 4,
   localparam int NW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [NW-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   // pointers wrap naturally at DEPTH because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + NW'(push) - NW'(pop);
      end
   // storage needs no reset; heads are only observed when count is non-zero
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= wdata;
   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/rca_wb_arbiter.sv
// rca_wb_arbiter: buffers per-channel RCA results and retires up to NUM_COMMIT per cycle round-robin (RCA_WB_BYPASS_EN enables zero-latency grant of empty channels)
module rca_wb_arbiter
   import rca_wb_pkg::*;
#(
   parameter int NUM_CHANNELS = 4,
   parameter int NUM_COMMIT = NUM_RCA_COMMIT,
   parameter int DEPTH = RCA_WB_DEPTH,
   parameter int ID_W = RCA_WB_ID_W,
   localparam int PW = $clog2(NUM_CHANNELS * DEPTH + 1)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 flush,
   input  logic [NUM_CHANNELS-1:0]              ch_valid,
   output logic [NUM_CHANNELS-1:0]              ch_ready,
   input  logic [NUM_CHANNELS-1:0][4:0]         ch_rd,
   input  logic [NUM_CHANNELS-1:0][ID_W-1:0]    ch_id,
   input  logic [NUM_CHANNELS-1:0][31:0]        ch_data,
   output logic [NUM_COMMIT-1:0]                retired,
   output logic [NUM_COMMIT-1:0][4:0]           retired_rd,
   output logic [NUM_COMMIT-1:0][ID_W-1:0]      retired_id,
   output logic [NUM_COMMIT-1:0][31:0]          retired_data,
   output logic [PW-1:0]                        pending
);
   localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
   localparam int EW = 5 + ID_W + 32;
   localparam int NW = $clog2(DEPTH + 1);
   logic [NUM_CHANNELS-1:0][EW-1:0] head, cand;
   logic [NUM_CHANNELS-1:0][NW-1:0] count;
   logic [NUM_CHANNELS-1:0]         avail, grant, push, pop, byp;
   logic [CW-1:0]                   rr_ptr, rr_next;
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign ch_ready[c] = count[c] != NW'(DEPTH) && !flush;
`ifdef RCA_WB_BYPASS_EN
      assign byp[c]  = rst && count[c] == '0 && ch_valid[c] && ch_rd[c] != 5'd0;
      assign cand[c] = count[c] != '0 ? head[c] : {ch_rd[c], ch_id[c], ch_data[c]};
`else
      assign byp[c]  = 1'b0;
      assign cand[c] = head[c];
`endif
      assign avail[c] = count[c] != '0 || byp[c];
      assign pop[c]   = grant[c] && count[c] != '0;
      assign push[c]  = ch_valid[c] && ch_ready[c] && ch_rd[c] != 5'd0 && !(byp[c] && grant[c]);
      rca_wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .flush (flush),
         .push  (push[c]),
         .pop   (pop[c]),
         .wdata ({ch_rd[c], ch_id[c], ch_data[c]}),
         .rdata (head[c]),
         .count (count[c])
      );
   end
   // scan channels from rr_ptr and hand the first NUM_COMMIT ready heads to ports in scan order
   always_comb begin
      int n, idx;
      n = 0;
      idx = 0;
      grant = '0;
      retired = '0;
      retired_rd = '0;
      retired_id = '0;
      retired_data = '0;
      rr_next = rr_ptr;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         idx = int'(rr_ptr) + k;
         idx = idx >= NUM_CHANNELS ? idx - NUM_CHANNELS : idx;
         if (!flush && avail[idx] && n < NUM_COMMIT) begin
            grant[idx] = 1'b1;
            retired[n] = 1'b1;
            {retired_rd[n], retired_id[n], retired_data[n]} = cand[idx];
            rr_next = idx == NUM_CHANNELS - 1 ? '0 : CW'(idx + 1);
            n++;
         end
      end
   end
   // round-robin pointer and total occupancy track the FIFOs edge by edge
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         rr_ptr  <= '0;
         pending <= '0;
      end else begin
         rr_ptr  <= rr_next;
         pending <= flush ? '0 : pending + PW'($countones(push)) - PW'($countones(pop));
      end
endmodule

// File: tb/tb_rca_wb_arbiter.sv
// tb_rca_wb_arbiter: randomized bench with a queue-based reference model plus directed literal checks
module tb_rca_wb_arbiter;
   import rca_wb_pkg::*;
   localparam int NC = 4, NM = 2, D = 4, IW = 3, PW = $clog2(NC * D + 1);
`ifdef RCA_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
   logic [NC-1:0]         ch_valid = '0, ch_ready;
   logic [NC-1:0][4:0]    ch_rd = '0;
   logic [NC-1:0][IW-1:0] ch_id = '0;
   logic [NC-1:0][31:0]   ch_data = '0;
   logic [NM-1:0]         retired;
   logic [NM-1:0][4:0]    retired_rd;
   logic [NM-1:0][IW-1:0] retired_id;
   logic [NM-1:0][31:0]   retired_data;
   logic [PW-1:0]         pending;
   int asserts = 0, fails = 0;
   typedef rca_wb_entry_t ent_t;
   ent_t q[NC][$];
   int rr = 0;

   always #5 clk = ~clk;

   rca_wb_arbiter #(.NUM_CHANNELS(NC), .NUM_COMMIT(NM), .DEPTH(D), .ID_W(IW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_rd(ch_rd), .ch_id(ch_id), .ch_data(ch_data),
      .retired(retired), .retired_rd(retired_rd), .retired_id(retired_id), .retired_data(retired_data),
      .pending(pending)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // reference model: per-channel queues, scanned round-robin from rr each cycle
   initial begin
      forever begin
         int n, last, tot, c;
         bit g[NC], bp[NC], acc[NC];
         logic [NC-1:0] er;
         ent_t ex[NM], val[NC];
         @(negedge clk);
         if (!rst) begin
            for (int i = 0; i < NC; i++) q[i].delete();
            rr = 0;
         end
         n = 0; last = -1; tot = 0;
         for (int i = 0; i < NC; i++) begin
            er[i] = q[i].size() != D && !flush;
            tot += q[i].size();
            g[i] = 0; bp[i] = 0;
         end
         for (int k = 0; k < NC; k++) begin
            bit b;
            c = (rr + k) % NC;
            b = BYP && rst && q[c].size() == 0 && ch_valid[c] && ch_rd[c] != 0;
            if (!flush && (q[c].size() > 0 || b) && n < NM) begin
               g[c] = 1; bp[c] = b;
               ex[n] = b ? ent_t'({ch_rd[c], ch_id[c], ch_data[c]}) : q[c][0];
               last = c;
               n++;
            end
         end
         for (int i = 0; i < NC; i++) begin
            acc[i] = ch_valid[i] && er[i] && ch_rd[i] != 0 && !bp[i];
            val[i] = {ch_rd[i], ch_id[i], ch_data[i]};
         end
         chk("ch_ready", 64'(ch_ready), 64'(er));
         chk("pending", 64'(pending), 64'(tot));
         for (int p = 0; p < NM; p++) begin
            chk($sformatf("retired[%0d]", p), 64'(retired[p]), 64'(p < n));
            if (p < n)
               chk($sformatf("port%0d rd/id/data", p), 64'({retired_rd[p], retired_id[p], retired_data[p]}), 64'(ex[p]));
         end
         @(posedge clk);
         if (!rst) begin
            for (int i = 0; i < NC; i++) q[i].delete();
            rr = 0;
         end else if (flush) begin
            for (int i = 0; i < NC; i++) q[i].delete();
         end else begin
            for (int i = 0; i < NC; i++) begin
               if (g[i] && !bp[i]) void'(q[i].pop_front());
               if (acc[i]) q[i].push_back(val[i]);
            end
            if (n > 0) rr = (last + 1) % NC;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      // single result through channel 0
      ch_valid[0] = 1'b1; ch_rd[0] = 5'd5; ch_id[0] = 3'd2; ch_data[0] = 32'hDEADBEEF;
      @(negedge clk);
`ifdef RCA_WB_BYPASS_EN
      chk("t1 bypass retired", 64'(retired[0]), 64'd1);
      chk("t1 bypass fields", 64'({retired_rd[0], retired_id[0], retired_data[0]}), {24'd0, 5'd5, 3'd2, 32'hDEADBEEF});
`else
      chk("t1 early retired", 64'(retired[0]), 64'd0);
`endif
      step();
      ch_valid = '0;
      @(negedge clk);
`ifdef RCA_WB_BYPASS_EN
      chk("t1 pending", 64'(pending), 64'd0);
      chk("t1 retired after", 64'(retired), 64'd0);
`else
      chk("t1 pending", 64'(pending), 64'd1);
      chk("t1 retired", 64'(retired[0]), 64'd1);
      chk("t1 fields", 64'({retired_rd[0], retired_id[0], retired_data[0]}), {24'd0, 5'd5, 3'd2, 32'hDEADBEEF});
`endif
      step();
      @(negedge clk);
      chk("t1 drained", 64'(pending), 64'd0);
      // rd == 0 is accepted and dropped
      step();
      ch_valid[2] = 1'b1; ch_rd[2] = 5'd0; ch_data[2] = 32'h1234;
      @(negedge clk);
      chk("rd0 ready", 64'(ch_ready[2]), 64'd1);
      step();
      ch_valid = '0;
      @(negedge clk);
      chk("rd0 pending", 64'(pending), 64'd0);
      chk("rd0 retired", 64'(retired), 64'd0);
      // reset so rr starts at 0, then all channels valid every cycle
      step();
      rst = 1'b0;
      #1;
      chk("rst pending", 64'(pending), 64'd0);
      step();
      rst = 1'b1;
      for (int c = 0; c < NC; c++) begin
         ch_valid[c] = 1'b1; ch_rd[c] = 5'(c + 1); ch_id[c] = IW'(c); ch_data[c] = 32'hA000 + c;
      end
      @(negedge clk);
      for (int w = 0; w < 4 && !retired[0]; w++) @(negedge clk);
      chk("burst first grant", 64'(retired), 64'd3);
      chk("burst grant 0,1", 64'({retired_rd[0], retired_rd[1]}), {54'd0, 5'd1, 5'd2});
      step();
      @(negedge clk);
      chk("burst grant 2,3", 64'({retired_rd[0], retired_rd[1]}), {54'd0, 5'd3, 5'd4});
      step();
      @(negedge clk);
      chk("burst grant 0,1 again", 64'({retired_rd[0], retired_rd[1]}), {54'd0, 5'd1, 5'd2});
      for (int w = 0; w < 12 && ch_ready == '1; w++) begin
         step();
         @(negedge clk);
      end
      chk("burst ready drops", 64'(ch_ready != '1), 64'd1);
      // flush with a backlog
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("flush retired", 64'(retired), 64'd0);
      chk("flush ready", 64'(ch_ready), 64'd0);
      chk("flush backlog", 64'(pending >= 6), 64'd1);
      step();
      flush = 1'b0;
      ch_valid = '0;
      @(negedge clk);
      chk("flush pending", 64'(pending), 64'd0);
      // channel 1 alone, enough entries to wrap its pointers
      for (int i = 0; i < 12; i++) begin
         step();
         ch_valid = 4'b0010; ch_rd[1] = 5'd7; ch_id[1] = IW'(i); ch_data[1] = 32'(i);
      end
      step();
      ch_valid = '0;
      repeat (4) step();
      // randomized traffic with occasional flush and one mid-burst reset
      for (int i = 0; i < 3000; i++) begin
         step();
         if (i == 1500) begin
            rst = 1'b0;
            #1;
            chk("midrst retired", 64'(retired), 64'd0);
            chk("midrst pending", 64'(pending), 64'd0);
         end
         if (i == 1503) rst = 1'b1;
         flush = $urandom_range(0, 39) == 0;
         ch_valid = ((i / 200) % 2) != 0 ? 4'($urandom) : 4'($urandom & $urandom);
         for (int c = 0; c < NC; c++) begin
            ch_rd[c] = $urandom_range(0, 5) == 0 ? 5'd0 : 5'($urandom);
            ch_id[c] = IW'($urandom);
            ch_data[c] = $urandom;
         end
      end
      step();
      ch_valid = '0;
      flush = 1'b0;
      repeat (12) step();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end
endmodule

// File: doc/rca_wb_arbiter.md
# rca_wb_arbiter

Parametrised writeback arbiter between the reconfigurable compute accelerator (RCA) unit and the register-file commit ports. It buffers per-channel RCA results (rd, id, data) in small FIFOs and drains up to NUM_COMMIT results per cycle with round-robin fairness. This replaces the fixed single-result RCA retire path with a scalable N-channel, M-port version with back-pressure and flush support.

## Interface
- NUM_CHANNELS, 4: RCA result channels (≥1)
- NUM_COMMIT, 2: register-file commit ports driven (1..NUM_CHANNELS)
- DEPTH, 4: entries per channel FIFO (power of two, ≥2)
- ID_W, 3: instruction id width (matches id_t)
- clk  in  1  core clock
- rst  in  1  reset; one clock, asynchronous, active-low
- flush  in  1  synchronous discard of all buffered results
- ch_valid  in  [NUM_CHANNELS]  channel result valid
- ch_ready  out  [NUM_CHANNELS]  channel can accept
- ch_rd  in  [NUM_CHANNELS][5]  destination register
- ch_id  in  [NUM_CHANNELS][ID_W]  instruction id
- ch_data  in  [NUM_CHANNELS][32]  result
- retired  out  [NUM_COMMIT]  commit port active this cycle
- retired_rd  out  [NUM_COMMIT][5]  commit rd
- retired_id  out  [NUM_COMMIT][ID_W]  commit id
- retired_data  out  [NUM_COMMIT][32]  commit data
- pending  out  $clog2(NUM_CHANNELS*DEPTH+1)  total buffered entries

## Operation
- Per channel: FIFO of DEPTH entries, rd/wr pointers with wrap at DEPTH, count 0..DEPTH.
- ch_ready[c] = (count[c] != DEPTH) && !flush; registered-state only, no pop-through when full.
- Handshake: transfer when ch_valid & ch_ready on rising edge; entries with ch_rd == 0 are accepted and dropped (never queued, never retired).
- Arbitration: rr_ptr register (0..NUM_CHANNELS-1). Scan channels rr_ptr, rr_ptr+1, … modulo NUM_CHANNELS; first NUM_COMMIT non-empty heads granted, assigned to ports 0,1,… in scan order. Granted heads popped at edge.
- rr_ptr next = (last granted channel + 1) mod NUM_CHANNELS; unchanged if no grant.
- Same rd on two ports same cycle: higher port index is later in program-arbitration order; register file applies higher index last.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
- flush: no retire this cycle, ch_ready all 0, at edge all counts/pointers cleared; rr_ptr kept.
- Reset (async, mid-operation allowed): counts, pointers, rr_ptr = 0; retired = 0, retired_rd/id/data = 0, ch_ready = 1 after release, pending = 0.

## Timing
- Outputs retired* combinational from FIFO heads and grant; grant from registered state only.
- Latency without bypass: accepted at edge t, earliest retire in cycle following t.
- Throughput: NUM_COMMIT results/cycle sustained; single channel max 1/cycle.
- pending registered, reflects state after last edge.

## Configuration
- RCA_WB_BYPASS_EN defined: a channel with empty FIFO whose ch_valid is high may be granted in the same cycle (zero latency); bypassed entry not written to FIFO; bypassed channels arbitrated identically in rr scan. ch_ready unaffected.
- Undefined: all results pass through FIFO; minimum one-cycle latency; no combinational path from ch_* to retired*.

## Structure
- Shared package: rca_wb_entry_t (rd, id, data) struct, RCA_WB_DEPTH default, NUM_RCA_COMMIT constant.
- One sub-module: rca_wb_fifo (single-channel DEPTH FIFO with count, push, pop, flush).
- Round-robin grant generator stays inline.

## Test plan
- Reset release, channel 0 sends rd=5,id=2,data=0xDEADBEEF -> next cycle retired[0]=1 with same fields, pending 1 then 0 (bypass: same cycle, pending stays 0).
- All 4 channels valid every cycle, NUM_COMMIT=2 -> 2 retires/cycle, grants rotate {0,1},{2,3},{0,1}; FIFOs fill, ch_ready drops at count 4.
- Channel 2 sends rd=0 -> accepted, never retired, pending unchanged.
- Fill channel 1 to DEPTH=4, hold other channels idle -> 4 retires in order on port 0, pointer wrap verified with 8 further entries.
- flush with 6 entries pending -> no retire that cycle, pending 0 next cycle, ch_ready 0 during flush.
- rst deasserted to 0 mid-burst -> all retired 0 immediately, pending 0, no stale entry after release.
